// File: rtl/pwm_gen_mc_if.sv
// Signal bundle between the register file and pwm_gen_mc. PWM_DEADTIME_EN adds the complementary-output pair.
// Timing: no handshake; the config side is sampled every cycle, and the output side is registered in the generator.
interface pwm_gen_mc_if #(
    parameter int CH = 4,
    parameter int CW = 16
);
    logic                pwm_en;
    logic                align;
    logic [7:0]          prescale;
    logic [CW-1:0]       period;
    logic [2*CH-1:0]     ch_mode;
    logic [CH*CW-1:0]    compare1;
    logic [CH*CW-1:0]    compare2;
    logic                update;
    logic [CW-1:0]       count_out;
    logic [CH-1:0]       pwm_out;
    logic                period_irq;
`ifdef PWM_DEADTIME_EN
    logic [7:0]          deadtime;
    logic [CH-1:0]       pwm_out_n;

    modport master (
        output pwm_en, align, prescale, period, ch_mode, compare1, compare2, update, deadtime,
        input  count_out, pwm_out, period_irq, pwm_out_n
    );
    modport slave (
        input  pwm_en, align, prescale, period, ch_mode, compare1, compare2, update, deadtime,
        output count_out, pwm_out, period_irq, pwm_out_n
    );
`else
    modport master (
        output pwm_en, align, prescale, period, ch_mode, compare1, compare2, update,
        input  count_out, pwm_out, period_irq
    );
    modport slave (
        input  pwm_en, align, prescale, period, ch_mode, compare1, compare2, update,
        output count_out, pwm_out, period_irq
    );
`endif
endinterface

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM: shared prescaled edge/center counter and double-buffered period/compare/mode. PWM_DEADTIME_EN adds dead-banded complementary outputs.
// Latency: pwm_out is one clk behind count_out, and period_irq is one clk after the boundary tick. No backpressure: it runs freely.
module pwm_gen_mc #(
    parameter int CH = 4,
    parameter int CW = 16
) (
    input  logic        clk,
    input  logic        rst,
    pwm_gen_mc_if.slave bus
);
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [7:0]       psc_q, psc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic [CW-1:0]    per_act_q, per_act_d;
    logic [2*CH-1:0]  mode_q, mode_d;
    logic [CH*CW-1:0] c1_q, c1_d;
    logic [CH*CW-1:0] c2_q, c2_d;
    logic             pend_q, pend_d;
    logic             irq_q, irq_d;
    logic [CH-1:0]    pwm_q, pwm_d;
    logic             tick;
    logic             bnd;
    logic             load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= DIR_UP;
        end else begin
            dir_q <= dir_d;
        end
    end

    // Timebase. A counter left above the top by an align switch walks back down.
    always_comb begin
        psc_d = psc_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        bnd   = 1'b0;
        tick  = bus.pwm_en && (psc_q >= bus.prescale);
        if (!bus.pwm_en) begin
            psc_d = 8'd0;
            cnt_d = '0;
            dir_d = DIR_UP;
        end else begin
            psc_d = tick ? 8'd0 : psc_q + 8'd1;
            if (tick) begin
                if (per_act_q == '0) begin
                    cnt_d = '0;
                    dir_d = DIR_UP;
                    bnd   = 1'b1;
                end else if (!bus.align) begin
                    dir_d = DIR_UP;
                    if (cnt_q >= per_act_q) begin
                        cnt_d = '0;
                        bnd   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else if (dir_q == DIR_UP && cnt_q < per_act_q) begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q + ONE == per_act_q) begin
                        dir_d = DIR_DOWN;
                    end
                end else if (cnt_q <= ONE) begin
                    cnt_d = '0;
                    dir_d = DIR_UP;
                    bnd   = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                    dir_d = DIR_DOWN;
                end
            end
        end
    end

    // Shadow-to-active transfer. While disabled, the active set tracks the inputs.
    always_comb begin
        per_act_d = per_act_q;
        mode_d    = mode_q;
        c1_d      = c1_q;
        c2_d      = c2_q;
        pend_d    = pend_q;
        load      = bnd && (pend_q || bus.update);
        if (!bus.pwm_en || load) begin
            per_act_d = bus.period;
            mode_d    = bus.ch_mode;
            c1_d      = bus.compare1;
            c2_d      = bus.compare2;
            pend_d    = 1'b0;
        end else if (bus.update) begin
            pend_d = 1'b1;
        end
        irq_d = bnd;
    end

    always_comb begin
        pwm_d = '0;
        if (bus.pwm_en) begin
            for (int i = 0; i < CH; i++) begin
                case (mode_q[2*i +: 2])
                    2'b01:   pwm_d[i] = (cnt_q < c1_q[i*CW +: CW]);
                    2'b10:   pwm_d[i] = (cnt_q >= c1_q[i*CW +: CW]);
                    2'b11:   pwm_d[i] = (cnt_q >= c1_q[i*CW +: CW]) && (cnt_q < c2_q[i*CW +: CW]);
                    default: pwm_d[i] = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q     <= 8'd0;
            cnt_q     <= '0;
            per_act_q <= '0;
            mode_q    <= '0;
            c1_q      <= '0;
            c2_q      <= '0;
            pend_q    <= 1'b0;
            irq_q     <= 1'b0;
            pwm_q     <= '0;
        end else begin
            psc_q     <= psc_d;
            cnt_q     <= cnt_d;
            per_act_q <= per_act_d;
            mode_q    <= mode_d;
            c1_q      <= c1_d;
            c2_q      <= c2_d;
            pend_q    <= pend_d;
            irq_q     <= irq_d;
            pwm_q     <= pwm_d;
        end
    end

    assign bus.count_out  = cnt_q;
    assign bus.period_irq = irq_q;

`ifdef PWM_DEADTIME_EN
    logic               en_q;
    logic [CH-1:0]      raw_prev_q, raw_prev_d;
    logic [CH-1:0][7:0] age_q, age_d, age_now;
    logic [CH-1:0]      p_out, n_out;

    // age_now counts clks since the raw level last changed. A side asserts only once that count reaches deadtime.
    always_comb begin
        raw_prev_d = pwm_q;
        age_d      = age_q;
        age_now    = '0;
        p_out      = '0;
        n_out      = '0;
        for (int i = 0; i < CH; i++) begin
            age_now[i] = (pwm_q[i] != raw_prev_q[i]) ? 8'd0 : age_q[i];
            if (!en_q) begin
                age_d[i] = 8'd0;
            end else if (age_now[i] != 8'hFF) begin
                age_d[i] = age_now[i] + 8'd1;
            end else begin
                age_d[i] = 8'hFF;
            end
            p_out[i] = en_q && pwm_q[i] && (age_now[i] >= bus.deadtime);
            n_out[i] = en_q && !pwm_q[i] && (age_now[i] >= bus.deadtime);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q       <= 1'b0;
            raw_prev_q <= '0;
            age_q      <= '0;
        end else begin
            en_q       <= bus.pwm_en;
            raw_prev_q <= raw_prev_d;
            age_q      <= age_d;
        end
    end

    assign bus.pwm_out   = p_out;
    assign bus.pwm_out_n = n_out;
`else
    assign bus.pwm_out = pwm_q;
`endif
endmodule

// File: tb/tb_pwm_gen_mc.sv
// Bench for pwm_gen_mc: table-driven duty/period vectors plus cycle-exact sequences.
// Expected values come from hand-derived constants pushed to queues.
module tb_pwm_gen_mc;
    localparam int CH = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pwm_gen_mc_if #(.CH(CH), .CW(CW)) bus ();
    pwm_gen_mc #(.CH(CH), .CW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        align;
        logic [7:0]  psc;
        logic [15:0] per;
        int          ch;
        logic [1:0]  mode;
        logic [15:0] c1;
        logic [15:0] c2;
        int          exp_hi;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        int idx;
        int ch;
        int hi;
        int cyc;
    } exp_t;

    typedef struct {
        int   cnt;
        logic pwm;
        logic irq;
    } cyc_t;

    vec_t vecs[10];
    exp_t sbq[$];
    cyc_t cq[$];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
        bus.ch_mode[2*ch +: 2]   = m;
        bus.compare1[ch*CW +: CW] = a;
        bus.compare2[ch*CW +: CW] = b;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.pwm_en   = 1'b0;
        bus.align    = 1'b0;
        bus.prescale = 8'd0;
        bus.period   = '0;
        bus.ch_mode  = '0;
        bus.compare1 = '0;
        bus.compare2 = '0;
        bus.update   = 1'b0;
`ifdef PWM_DEADTIME_EN
        bus.deadtime = 8'd0;
`endif
        step();
        rst = 1'b0;
    endtask

    // One disabled clk loads the active set transparently, then enable.
    task automatic apply_vec(input vec_t v);
        do_reset();
        bus.align    = v.align;
        bus.prescale = v.psc;
        bus.period   = v.per;
        set_ch(v.ch, v.mode, v.c1, v.c2);
        step();
        bus.pwm_en = 1'b1;
    endtask

    task automatic wait_irq(input string nm);
        int n;
        n = 0;
        while (bus.period_irq !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check({nm, "_irq_seen"}, bus.period_irq, 1);
    endtask

    task automatic measure();
        exp_t e;
        int   hi, oth, irqs;
        e = sbq.pop_front();
        hi = 0; oth = 0; irqs = 0;
        wait_irq($sformatf("v%0d", e.idx));
        for (int k = 1; k <= e.cyc; k++) begin
            step();
            hi   += int'(bus.pwm_out[e.ch]);
            oth  += $countones(bus.pwm_out) - int'(bus.pwm_out[e.ch]);
            irqs += int'(bus.period_irq);
        end
        check($sformatf("v%0d_high_clks", e.idx), hi, e.hi);
        check($sformatf("v%0d_other_ch", e.idx), oth, 0);
        check($sformatf("v%0d_irq_count", e.idx), irqs, 1);
        check($sformatf("v%0d_irq_at_end", e.idx), bus.period_irq, 1);
    endtask

    task automatic run_cq(input int ch, input string nm, input int upd_k, input logic [15:0] upd_c1);
        cyc_t e;
        int   k;
        k = 0;
        while (cq.size() > 0) begin
            k++;
            if (k == upd_k) begin
                bus.compare1[ch*CW +: CW] = upd_c1;
                bus.update = 1'b1;
            end else begin
                bus.update = 1'b0;
            end
            step();
            e = cq.pop_front();
            check($sformatf("%s_cnt_k%0d", nm, k), bus.count_out, e.cnt);
            check($sformatf("%s_pwm_k%0d", nm, k), bus.pwm_out[ch], e.pwm);
            check($sformatf("%s_irq_k%0d", nm, k), bus.period_irq, e.irq);
        end
        bus.update = 1'b0;
    endtask

    initial begin
        int cseq[16] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 2, 2, 1, 1, 0};
        int prev;
        int ph, pn, both;

        vecs[0] = '{align:1'b0, psc:8'd0, per:16'd9, ch:0, mode:2'b01, c1:16'd3,  c2:16'd0, exp_hi:3,  exp_cyc:10};
        vecs[1] = '{align:1'b1, psc:8'd1, per:16'd4, ch:1, mode:2'b11, c1:16'd1,  c2:16'd3, exp_hi:8,  exp_cyc:16};
        vecs[2] = '{align:1'b0, psc:8'd0, per:16'd9, ch:0, mode:2'b01, c1:16'd0,  c2:16'd0, exp_hi:0,  exp_cyc:10};
        vecs[3] = '{align:1'b0, psc:8'd0, per:16'd9, ch:0, mode:2'b01, c1:16'd20, c2:16'd0, exp_hi:10, exp_cyc:10};
        vecs[4] = '{align:1'b0, psc:8'd0, per:16'd9, ch:2, mode:2'b11, c1:16'd5,  c2:16'd5, exp_hi:0,  exp_cyc:10};
        vecs[5] = '{align:1'b0, psc:8'd0, per:16'd9, ch:2, mode:2'b10, c1:16'd3,  c2:16'd0, exp_hi:7,  exp_cyc:10};
        vecs[6] = '{align:1'b0, psc:8'd2, per:16'd0, ch:3, mode:2'b01, c1:16'd1,  c2:16'd0, exp_hi:3,  exp_cyc:3};
        vecs[7] = '{align:1'b1, psc:8'd0, per:16'd5, ch:3, mode:2'b01, c1:16'd2,  c2:16'd0, exp_hi:3,  exp_cyc:10};
        vecs[8] = '{align:1'b0, psc:8'd3, per:16'd3, ch:1, mode:2'b11, c1:16'd1,  c2:16'd3, exp_hi:8,  exp_cyc:16};
        vecs[9] = '{align:1'b0, psc:8'd0, per:16'd9, ch:0, mode:2'b00, c1:16'd5,  c2:16'd0, exp_hi:0,  exp_cyc:10};

        // Reset dominates even with the enable and a live config applied.
        do_reset();
        rst          = 1'b1;
        bus.pwm_en   = 1'b1;
        bus.period   = 16'd3;
        bus.ch_mode  = '1;
        bus.compare1 = '1;
        bus.compare2 = '1;
        step(); step(); step();
        check("reset_count", bus.count_out, 0);
        check("reset_pwm", bus.pwm_out, 0);
        check("reset_irq", bus.period_irq, 0);

        for (int i = 0; i < 10; i++) begin
            apply_vec(vecs[i]);
            sbq.push_back('{idx:i, ch:vecs[i].ch, hi:vecs[i].exp_hi, cyc:vecs[i].exp_cyc});
            measure();
        end

        // Center-aligned count sequence with each value held two clks.
        apply_vec(vecs[1]);
        wait_irq("ctr");
        prev = 0;
        for (int k = 1; k <= 16; k++) begin
            cq.push_back('{cnt:cseq[k-1], pwm:(prev == 1 || prev == 2), irq:(k == 16)});
            prev = cseq[k-1];
        end
        run_cq(1, "ctr", -1, 16'd0);

        // Mid-period update: old duty finishes, new duty begins after the boundary.
        apply_vec(vecs[0]);
        wait_irq("upd");
        for (int k = 1; k <= 20; k++) begin
            cq.push_back('{cnt:(k % 10), pwm:((k <= 3) || (k >= 11 && k <= 17)), irq:(k == 10 || k == 20)});
        end
        run_cq(0, "upd", 2, 16'd7);

        // Disable mid-run with a new compare, then re-enable.
        bus.pwm_en = 1'b0;
        bus.compare1[0 +: CW] = 16'd5;
        for (int k = 1; k <= 5; k++) begin
            cq.push_back('{cnt:0, pwm:1'b0, irq:1'b0});
        end
        run_cq(0, "dis", -1, 16'd0);
        bus.pwm_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cq.push_back('{cnt:(k % 10), pwm:(k <= 5), irq:(k == 10)});
        end
        run_cq(0, "reen", -1, 16'd0);

        // Asynchronous reset mid-count.
        step(); step(); step();
        check("pre_rst_count", bus.count_out, 3);
        rst = 1'b1;
        #1;
        check("async_rst_count", bus.count_out, 0);
        check("async_rst_pwm", bus.pwm_out, 0);
        check("async_rst_irq", bus.period_irq, 0);
        step();
        rst = 1'b0;

`ifdef PWM_DEADTIME_EN
        apply_vec('{align:1'b0, psc:8'd0, per:16'd9, ch:0, mode:2'b01, c1:16'd5, c2:16'd0, exp_hi:0, exp_cyc:10});
        bus.deadtime = 8'd2;
        wait_irq("dt");
        ph = 0; pn = 0; both = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            ph   += int'(bus.pwm_out[0]);
            pn   += int'(bus.pwm_out_n[0]);
            both += int'(bus.pwm_out[0] & bus.pwm_out_n[0]);
        end
        check("dt_p_high", ph, 3);
        check("dt_n_high", pn, 3);
        check("dt_overlap", both, 0);
`else
        ph = 0; pn = 0; both = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
